// File: rtl/verify_online_sk_pkg.sv
// Shared constants, parameter-set tables, FSM encoding and P251 byte arithmetic
// for the verifier-side online phase.
package verify_online_sk_pkg;

   localparam int TAU_L1 = 17;
   localparam int TAU_L3 = 26;
   localparam int TAU_L5 = 34;
   localparam int T_L1   = 3;
   localparam int T_L3   = 3;
   localparam int T_L5   = 4;

   localparam int         D_HYPERCUBE = 8;
   localparam logic [7:0] P251_MOD    = 8'd251;

   function automatic int broad_plain_size(input int t);
      return 64 * t;
   endfunction

   function automatic int broad_share_size(input int t);
      return 96 * t;
   endfunction

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_LOAD,
      S_CHECK,
      S_LOOP,
      S_PC_WAIT,
      S_RECOVER,
      S_EMIT,
      S_NEXT_TAU,
      S_FINISH
   } state_t;

   // Operands are assumed already reduced below 251.
   function automatic logic [7:0] p251_add(input logic [7:0] a, input logic [7:0] b);
      logic [8:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= 9'd251) s = s - 9'd251;
      return s[7:0];
   endfunction

   function automatic logic [7:0] p251_neg(input logic [7:0] a);
      return (a == 8'd0) ? 8'd0 : P251_MOD - a;
   endfunction

endpackage

// File: rtl/verify_online_sk_lane.sv
// Byte-lane field arithmetic: running accumulation and recovery of a hidden
// value as plain minus accumulator (P251 mod arithmetic or GF256 XOR).
module field_lane_addsub
   import verify_online_sk_pkg::*;
#(
   parameter string FIELD   = "P251",
   parameter int    N_BYTES = 12
) (
   input  logic [8*N_BYTES-1:0] acc,
   input  logic [8*N_BYTES-1:0] share,
   input  logic [8*N_BYTES-1:0] plain,
   output logic [8*N_BYTES-1:0] acc_sum,
   output logic [8*N_BYTES-1:0] recovered
);

   for (genvar i = 0; i < N_BYTES; i++) begin : g_lane
      if (FIELD == "GF256") begin : g_gf
         assign acc_sum[8*i +: 8]   = acc[8*i +: 8] ^ share[8*i +: 8];
         assign recovered[8*i +: 8] = plain[8*i +: 8] ^ acc[8*i +: 8];
      end else begin : g_p251
         assign acc_sum[8*i +: 8]   = p251_add(acc[8*i +: 8], share[8*i +: 8]);
         assign recovered[8*i +: 8] = p251_add(plain[8*i +: 8], p251_neg(acc[8*i +: 8]));
      end
   end

endmodule

// File: rtl/verify_online_sk.sv
// Verifier online phase: runs party computation for the opened parties, recovers
// the hidden share from the plain broadcast, and streams all shares in party order.
module verify_online_sk
   import verify_online_sk_pkg::*;
#(
   parameter string PARAMETER_SET = "L1",
   parameter string FIELD         = "P251",
   parameter int    TAU = (PARAMETER_SET == "L5") ? TAU_L5 : (PARAMETER_SET == "L3") ? TAU_L3 : TAU_L1,
   parameter int    T   = (PARAMETER_SET == "L5") ? T_L5 : (PARAMETER_SET == "L3") ? T_L3 : T_L1,
   localparam int   TAU_W   = (TAU > 1) ? $clog2(TAU) : 1,
   localparam int   PARTY_W = $clog2(D_HYPERCUBE),
   localparam int   LANE_W  = 32 * T,
   localparam int   PLAIN_W = broad_plain_size(T),
   localparam int   SHARE_W = broad_share_size(T)
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_start,
   output logic               o_done,
   output logic               o_err,
   output logic [TAU_W-1:0]   o_tau_addr,
   output logic               o_tau_rd,
   input  logic [PARTY_W:0]   i_i_star,
   input  logic [PLAIN_W-1:0] i_broad_plain,
   output logic               o_pc_start,
   output logic [PARTY_W-1:0] o_pc_party,
   output logic [TAU_W-1:0]   o_pc_tau,
   input  logic               i_pc_done,
   input  logic [LANE_W-1:0]  i_pc_alpha,
   input  logic [LANE_W-1:0]  i_pc_beta,
   input  logic [LANE_W-1:0]  i_pc_v,
   output logic [SHARE_W-1:0] o_broad_share,
   output logic               o_broad_share_valid,
   input  logic               i_broad_share_ready
);

   localparam logic [PARTY_W:0]   D_CNT      = (PARTY_W+1)'(D_HYPERCUBE);
   localparam logic [PARTY_W-1:0] LAST_PARTY = PARTY_W'(D_HYPERCUBE - 1);
   localparam logic [TAU_W-1:0]   LAST_TAU   = TAU_W'(TAU - 1);

   state_t               state, state_nxt;
   logic [TAU_W-1:0]     count_tau;
   logic [PARTY_W:0]     count_d;
   logic [PARTY_W:0]     star;
   logic [PARTY_W-1:0]   emit_idx;
   logic [PLAIN_W-1:0]   plain;
   logic                 err;
   logic [LANE_W-1:0]    acc_alpha, acc_beta, acc_v;
   logic [LANE_W-1:0]    sum_alpha, sum_beta, sum_v;
   logic [LANE_W-1:0]    rec_alpha, rec_beta, rec_v;
   logic [SHARE_W-1:0]   share_buf [D_HYPERCUBE];
   logic                 star_bad;

   assign star_bad = (star >= D_CNT);

   field_lane_addsub #(.FIELD(FIELD), .N_BYTES(4*T)) u_alpha (
      .acc(acc_alpha), .share(i_pc_alpha), .plain(plain[PLAIN_W-1:LANE_W]),
      .acc_sum(sum_alpha), .recovered(rec_alpha));

   field_lane_addsub #(.FIELD(FIELD), .N_BYTES(4*T)) u_beta (
      .acc(acc_beta), .share(i_pc_beta), .plain(plain[LANE_W-1:0]),
      .acc_sum(sum_beta), .recovered(rec_beta));

   // v has no plain counterpart: recovering against zero yields neg(acc_v).
   field_lane_addsub #(.FIELD(FIELD), .N_BYTES(4*T)) u_v (
      .acc(acc_v), .share(i_pc_v), .plain({LANE_W{1'b0}}),
      .acc_sum(sum_v), .recovered(rec_v));

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state     <= S_IDLE;
         count_tau <= '0;
         count_d   <= '0;
         star      <= '0;
         emit_idx  <= '0;
         plain     <= '0;
         err       <= 1'b0;
         acc_alpha <= '0;
         acc_beta  <= '0;
         acc_v     <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            S_IDLE: if (i_start) begin
               err       <= 1'b0;
               count_tau <= '0;
            end
            S_LOAD: begin
               star      <= i_i_star;
               plain     <= i_broad_plain;
               count_d   <= '0;
               acc_alpha <= '0;
               acc_beta  <= '0;
               acc_v     <= '0;
            end
            S_CHECK:   if (star_bad) err <= 1'b1;
            S_LOOP:    if (count_d != D_CNT && count_d == star) count_d <= count_d + 1'b1;
            S_PC_WAIT: if (i_pc_done) begin
               acc_alpha <= sum_alpha;
               acc_beta  <= sum_beta;
               acc_v     <= sum_v;
               count_d   <= count_d + 1'b1;
            end
            S_RECOVER:  emit_idx <= '0;
            S_EMIT:     if (i_broad_share_ready) emit_idx <= emit_idx + 1'b1;
            S_NEXT_TAU: count_tau <= count_tau + 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (state == S_PC_WAIT && i_pc_done)
         share_buf[count_d[PARTY_W-1:0]] <= {i_pc_alpha, i_pc_beta, i_pc_v};
      else if (state == S_RECOVER)
         share_buf[star[PARTY_W-1:0]] <= {rec_alpha, rec_beta, rec_v};
   end

   always_comb begin
      state_nxt           = state;
      o_tau_rd            = 1'b0;
      o_pc_start          = 1'b0;
      o_broad_share_valid = 1'b0;
      o_done              = 1'b0;
      case (state)
         S_IDLE:    if (i_start) state_nxt = S_FETCH;
         S_FETCH: begin
            o_tau_rd  = 1'b1;
            state_nxt = S_LOAD;
         end
         S_LOAD:    state_nxt = S_CHECK;
         S_CHECK:   state_nxt = star_bad ? S_FINISH : S_LOOP;
         S_LOOP: begin
            if (count_d == D_CNT) begin
               state_nxt = S_RECOVER;
            end else if (count_d != star) begin
               o_pc_start = 1'b1;
               state_nxt  = S_PC_WAIT;
            end
         end
         S_PC_WAIT: if (i_pc_done) state_nxt = S_LOOP;
         S_RECOVER: state_nxt = S_EMIT;
         S_EMIT: begin
            o_broad_share_valid = 1'b1;
            if (i_broad_share_ready && emit_idx == LAST_PARTY) state_nxt = S_NEXT_TAU;
         end
         S_NEXT_TAU: state_nxt = (count_tau == LAST_TAU) ? S_FINISH : S_FETCH;
         S_FINISH: begin
            o_done    = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign o_err         = err;
   assign o_tau_addr    = count_tau;
   assign o_pc_tau      = count_tau;
   assign o_pc_party    = count_d[PARTY_W-1:0];
   assign o_broad_share = o_broad_share_valid ? share_buf[emit_idx] : '0;

endmodule

// File: tb/tb_verify_online_sk.sv
// Directed bench: P251 and GF256 instances run in lockstep against a party-computation
// model whose opened shares are alpha=party+1, beta=v=1, with plain bytes 0x05.
`timescale 1ns/1ps
module tb_verify_online_sk;

   localparam int TAU = 4;
   localparam int T   = 3;
   localparam int W   = 32 * T;
   localparam int PW  = 64 * T;
   localparam int SW  = 96 * T;

   typedef struct {
      logic [3:0] star;
      logic [7:0] a_p, b_p, v_p;
      logic [7:0] a_g, b_g, v_g;
   } vec_t;

   vec_t vec [3];

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          ready = 1'b1;
   logic          clr = 1'b0;
   logic          pc_done = 1'b0;
   logic [W-1:0]  pc_alpha = '0, pc_beta = '0, pc_v = '0;
   logic [3:0]    star_tab [TAU];
   logic [3:0]    i_star;
   logic [PW-1:0] plain;

   logic          done_p, err_p, tau_rd_p, pc_start_p, valid_p;
   logic          done_g, err_g, tau_rd_g, pc_start_g, valid_g;
   logic [1:0]    tau_addr_p, pc_tau_p, tau_addr_g, pc_tau_g;
   logic [2:0]    pc_party_p, pc_party_g;
   logic [SW-1:0] share_p, share_g;

   int checks = 0;
   int errors = 0;
   int xfer, done_cnt, pc_cnt, vld_cnt, stall_seen;
   logic          prev_stall;
   logic [SW-1:0] prev_share;
   bit rand_ready = 1'b0;
   bit stall_used = 1'b0;
   int stall_left = 0;

   always #5 clk = ~clk;

   assign i_star = star_tab[tau_addr_p];
   assign plain  = {(PW/8){8'h05}};

   verify_online_sk #(.FIELD("P251"), .TAU(TAU)) dut_p (
      .i_clk(clk), .i_rst(rst), .i_start(start), .o_done(done_p), .o_err(err_p),
      .o_tau_addr(tau_addr_p), .o_tau_rd(tau_rd_p), .i_i_star(i_star), .i_broad_plain(plain),
      .o_pc_start(pc_start_p), .o_pc_party(pc_party_p), .o_pc_tau(pc_tau_p),
      .i_pc_done(pc_done), .i_pc_alpha(pc_alpha), .i_pc_beta(pc_beta), .i_pc_v(pc_v),
      .o_broad_share(share_p), .o_broad_share_valid(valid_p), .i_broad_share_ready(ready));

   verify_online_sk #(.FIELD("GF256"), .TAU(TAU)) dut_g (
      .i_clk(clk), .i_rst(rst), .i_start(start), .o_done(done_g), .o_err(err_g),
      .o_tau_addr(tau_addr_g), .o_tau_rd(tau_rd_g), .i_i_star(i_star), .i_broad_plain(plain),
      .o_pc_start(pc_start_g), .o_pc_party(pc_party_g), .o_pc_tau(pc_tau_g),
      .i_pc_done(pc_done), .i_pc_alpha(pc_alpha), .i_pc_beta(pc_beta), .i_pc_v(pc_v),
      .o_broad_share(share_g), .o_broad_share_valid(valid_g), .i_broad_share_ready(ready));

   task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   function automatic logic [W-1:0] rep8(input logic [7:0] b);
      logic [W-1:0] r;
      for (int i = 0; i < W/8; i++) r[8*i +: 8] = b;
      return r;
   endfunction

   function automatic logic [SW-1:0] exp_share(input int n, input bit gf);
      int r;
      int p;
      logic [3:0] s;
      r = n / 8;
      p = n % 8;
      s = star_tab[r];
      if (p == int'(s)) begin
         for (int k = 0; k < 3; k++)
            if (vec[k].star == s)
               return gf ? {rep8(vec[k].a_g), rep8(vec[k].b_g), rep8(vec[k].v_g)}
                         : {rep8(vec[k].a_p), rep8(vec[k].b_p), rep8(vec[k].v_p)};
         return '0;
      end
      return {rep8(8'(p + 1)), rep8(8'h01), rep8(8'h01)};
   endfunction

   // Stream scoreboard, stall-stability and lockstep monitor.
   always @(negedge clk) begin
      if (rst || clr) begin
         xfer = 0; done_cnt = 0; pc_cnt = 0; vld_cnt = 0; stall_seen = 0;
         prev_stall = 1'b0;
         prev_share = '0;
      end else begin
         check("lockstep", {done_g, err_g, tau_addr_g, tau_rd_g, pc_start_g, pc_party_g, pc_tau_g, valid_g},
                           {done_p, err_p, tau_addr_p, tau_rd_p, pc_start_p, pc_party_p, pc_tau_p, valid_p});
         if (prev_stall) check("stall_hold", {valid_p, share_p}, {1'b1, prev_share});
         if (valid_p) vld_cnt++;
         if (valid_p && !ready) stall_seen++;
         if (valid_p && ready) begin
            check("share_p251", share_p, exp_share(xfer, 1'b0));
            check("share_gf256", share_g, exp_share(xfer, 1'b1));
            xfer++;
         end
         if (pc_start_p) begin
            pc_cnt++;
            if (xfer / 8 < TAU) begin
               check("pc_skip_hidden", ({1'b0, pc_party_p} != star_tab[xfer/8]), 1);
               check("pc_tau", pc_tau_p, xfer / 8);
            end
         end
         if (done_p) done_cnt++;
         prev_stall = valid_p && !ready;
         prev_share = share_p;
      end
   end

   // Party-computation model: answers each start after 1..3 cycles.
   initial begin
      logic [2:0] party;
      forever begin
         @(negedge clk);
         pc_done = 1'b0;
         if (pc_start_p && !rst) begin
            party = pc_party_p;
            repeat (1 + $urandom_range(0, 2)) @(negedge clk);
            pc_alpha = rep8({5'd0, party} + 8'd1);
            pc_beta  = rep8(8'h01);
            pc_v     = rep8(8'h01);
            pc_done  = 1'b1;
         end
      end
   end

   // Ready source: constant high, or random with one forced 5-cycle stall mid-stream.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_ready && !stall_used && xfer == 12) begin
            stall_left = 5;
            stall_used = 1'b1;
         end
         if (stall_left > 0) begin
            ready = 1'b0;
            stall_left--;
         end else if (rand_ready) begin
            ready = ($urandom_range(0, 3) != 0);
         end else begin
            ready = 1'b1;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   task automatic set_tab(input logic [15:0] v);
      for (int r = 0; r < TAU; r++) star_tab[r] = v[4*r +: 4];
   endtask

   task automatic clear_sb();
      @(posedge clk); #1 clr = 1'b1;
      @(posedge clk); #1 clr = 1'b0;
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic run(input string name, input int budget, output int cyc, output logic err0);
      pulse_start();
      cyc = 0;
      err0 = 1'b1;
      do begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) err0 = err_p;
      end while (!done_p && cyc < budget);
      check({name, "_done_in_budget"}, done_p, 1);
   endtask

   task automatic post_run(input string name, input int n_xfer, input int n_pc, input logic e);
      repeat (2) @(negedge clk);
      check({name, "_xfers"}, xfer, n_xfer);
      check({name, "_done_once"}, done_cnt, 1);
      check({name, "_pc_starts"}, pc_cnt, n_pc);
      check({name, "_err"}, err_p, e);
   endtask

   initial begin
      int   cyc;
      logic err0;
      vec[0] = '{4'd0, 8'hDD, 8'hF9, 8'hF4, 8'h0C, 8'h04, 8'h01};
      vec[1] = '{4'd2, 8'hDF, 8'hF9, 8'hF4, 8'h0E, 8'h04, 8'h01};
      vec[2] = '{4'd7, 8'hE4, 8'hF9, 8'hF4, 8'h05, 8'h04, 8'h01};
      set_tab(16'h2702);

      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_ctrl", {done_p, err_p, tau_rd_p, pc_start_p, valid_p, tau_addr_p, pc_party_p, pc_tau_p}, 0);
      check("reset_share", share_p, 0);
      @(posedge clk); #1 rst = 1'b0;

      // Run A: hidden index 2, 0, 7, 2 with ready always high.
      run("A", 3000, cyc, err0);
      post_run("A", 32, 28, 1'b0);

      // Run B: out-of-range hidden index aborts after CHECK.
      clear_sb();
      set_tab(16'h0009);
      run("B", 200, cyc, err0);
      check("B_done_latency", cyc, 4);
      post_run("B", 0, 0, 1'b1);
      check("B_no_valid", vld_cnt, 0);

      // Run C: error cleared by the next start; random backpressure with a long stall.
      clear_sb();
      set_tab(16'h7027);
      rand_ready = 1'b1;
      run("C", 4000, cyc, err0);
      check("C_err_cleared", err0, 0);
      post_run("C", 32, 28, 1'b0);
      check("C_stall_cycles", (stall_seen >= 5), 1);
      rand_ready = 1'b0;

      // Run D: reset while waiting on the party computation of repetition 3.
      clear_sb();
      set_tab(16'h2270);
      pulse_start();
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!(pc_start_p && pc_tau_p == 2'd3) && cyc < 3000);
      check("D_reach_rep3", (pc_start_p && pc_tau_p == 2'd3), 1);
      check("D_xfers_before_reset", xfer, 24);
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      check("D_reset_mid_op", {done_p, valid_p, pc_start_p, tau_rd_p, err_p}, 0);
      repeat (4) @(posedge clk);
      #1 rst = 1'b0;

      // Run E: clean run after the mid-operation reset.
      set_tab(16'h2702);
      run("E", 3000, cyc, err0);
      post_run("E", 32, 28, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
